flp_norm: RTL and testbench

FLP_NORM -- requirements
Module: flp_norm

---
 rtl/flp_norm.sv | 128 ++++++++++++
 tb/tb_flp_norm.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/flp_norm.sv
// Post-add normalizer for a sign-magnitude floating-point adder.
// Shifts the significand one bit per cycle until the hidden bit is set, flagging zero/overflow/underflow.
module flp_norm #(
    parameter int WIDTH = 24,
    parameter int EXPW  = 8
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             i_valid,
    input  logic             i_sn,
    input  logic [WIDTH:0]   i_sg,
    input  logic [EXPW-1:0]  i_exp,
    input  logic             i_zero,
    output logic             o_rdy,
    output logic             o_valid,
    input  logic             i_rdy,
    output logic             o_sn,
    output logic [WIDTH-1:0] o_sg,
    output logic [EXPW-1:0]  o_exp,
    output logic             o_zero,
    output logic             o_ovf,
    output logic             o_udf
);

    localparam logic [EXPW-1:0] EXP_MAX = '1;
    localparam logic [EXPW-1:0] EXP_OVF = EXP_MAX - EXPW'(1);
    localparam logic [EXPW-1:0] EXP_ONE = EXPW'(1);

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    state_t          r_state;
    logic            r_rdy;
    logic            r_valid;
    logic            r_sn;
    logic [WIDTH:0]  r_sg;
    logic [EXPW-1:0] r_exp;
    logic            r_in_zero;
    logic            r_in_expmax;
    logic            r_zf;
    logic            r_ovf;
    logic            r_udf;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= IDLE;
            r_rdy       <= 1'b1;
            r_valid     <= 1'b0;
            r_sn        <= 1'b0;
            r_sg        <= '0;
            r_exp       <= '0;
            r_in_zero   <= 1'b0;
            r_in_expmax <= 1'b0;
            r_zf        <= 1'b0;
            r_ovf       <= 1'b0;
            r_udf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_sn        <= i_sn;
                        r_sg        <= i_sg;
                        r_in_zero   <= i_zero;
                        r_in_expmax <= (i_exp == EXP_MAX);
                        // Exponent 0 encodes a denormal whose true scale matches exponent 1
                        r_exp       <= (i_exp == '0) ? EXP_ONE : i_exp;
                        r_zf        <= 1'b0;
                        r_ovf       <= 1'b0;
                        r_udf       <= 1'b0;
                        r_rdy       <= 1'b0;
                        r_state     <= NORM;
                    end
                end
                NORM: begin
                    if (r_in_zero || (r_sg == '0)) begin
                        r_sg    <= '0;
                        r_exp   <= '0;
                        r_zf    <= 1'b1;
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end else if (r_in_expmax || (r_sg[WIDTH] && (r_exp == EXP_OVF))) begin
                        r_sg    <= '0;
                        r_exp   <= EXP_MAX;
                        r_ovf   <= 1'b1;
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end else if (r_sg[WIDTH]) begin
                        r_sg  <= r_sg >> 1;
                        r_exp <= r_exp + EXP_ONE;
                    end else if (r_sg[WIDTH-1]) begin
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end else if (r_exp <= EXP_ONE) begin
                        // Cannot shift further without going below the minimum exponent
                        r_exp   <= '0;
                        r_udf   <= 1'b1;
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_sg  <= r_sg << 1;
                        r_exp <= r_exp - EXP_ONE;
                    end
                end
                DONE: begin
                    if (i_rdy) begin
                        r_valid <= 1'b0;
                        r_rdy   <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_rdy   <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_rdy   = r_rdy;
    assign o_valid = r_valid;
    assign o_sn    = r_sn;
    assign o_sg    = r_sg[WIDTH-1:0];
    assign o_exp   = r_exp;
    assign o_zero  = r_zf;
    assign o_ovf   = r_ovf;
    assign o_udf   = r_udf;

endmodule

// File: tb/tb_flp_norm.sv
// Bench for flp_norm: table of operands with hand-derived results, scoreboard queue,
// plus back-pressure and mid-operation reset sequences.
module tb_flp_norm;

    localparam int WIDTH = 24;
    localparam int EXPW  = 8;

    logic             clk = 1'b0;
    logic             nrst;
    logic             i_valid;
    logic             i_sn;
    logic [WIDTH:0]   i_sg;
    logic [EXPW-1:0]  i_exp;
    logic             i_zero;
    logic             o_rdy;
    logic             o_valid;
    logic             i_rdy;
    logic             o_sn;
    logic [WIDTH-1:0] o_sg;
    logic [EXPW-1:0]  o_exp;
    logic             o_zero;
    logic             o_ovf;
    logic             o_udf;

    flp_norm #(.WIDTH(WIDTH), .EXPW(EXPW)) dut (
        .clk(clk), .nrst(nrst), .i_valid(i_valid), .i_sn(i_sn), .i_sg(i_sg),
        .i_exp(i_exp), .i_zero(i_zero), .o_rdy(o_rdy), .o_valid(o_valid),
        .i_rdy(i_rdy), .o_sn(o_sn), .o_sg(o_sg), .o_exp(o_exp),
        .o_zero(o_zero), .o_ovf(o_ovf), .o_udf(o_udf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             sn;
        logic [WIDTH:0]   sg;
        logic [EXPW-1:0]  ex;
        logic             zero;
        logic             esn;
        logic [WIDTH-1:0] esg;
        logic [EXPW-1:0]  eex;
        logic             ezf;
        logic             eovf;
        logic             eudf;
        int               lat;
    } vec_t;

    vec_t vecs[14];
    vec_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic sn, input logic [WIDTH:0] sg, input logic [EXPW-1:0] ex,
                                input logic zero, input logic esn, input logic [WIDTH-1:0] esg,
                                input logic [EXPW-1:0] eex, input logic ezf, input logic eovf,
                                input logic eudf, input int lat);
        vec_t v;
        v.sn = sn; v.sg = sg; v.ex = ex; v.zero = zero;
        v.esn = esn; v.esg = esg; v.eex = eex;
        v.ezf = ezf; v.eovf = eovf; v.eudf = eudf; v.lat = lat;
        return v;
    endfunction

    // Drive one operand, push its expectation, wait for the result and compare.
    // Returns at the sampling point where o_valid is first seen (state DONE).
    task automatic run_vec(input vec_t v, input string tag);
        vec_t e;
        int   lat;
        bit   seen;
        @(negedge clk);
        chk({tag, ".rdy_before"}, 32'(o_rdy), 32'd1);
        i_valid = 1'b1; i_sn = v.sn; i_sg = v.sg; i_exp = v.ex; i_zero = v.zero;
        @(posedge clk);
        sb_q.push_back(v);
        #1;
        // Garbage with i_valid held high must not disturb the latched operand
        i_sn = ~v.sn; i_sg = 25'($urandom); i_exp = 8'($urandom); i_zero = ~v.zero;
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (o_valid) seen = 1'b1;
        end
        i_valid = 1'b0;
        e = sb_q.pop_front();
        if (!seen) begin
            chk({tag, ".timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, ".lat"}, 32'(lat), 32'(e.lat));
            chk({tag, ".rdy_in_done"}, 32'(o_rdy), 32'd0);
            chk({tag, ".sn"}, 32'(o_sn), 32'(e.esn));
            chk({tag, ".sg"}, 32'(o_sg), 32'(e.esg));
            chk({tag, ".exp"}, 32'(o_exp), 32'(e.eex));
            chk({tag, ".flags"}, 32'({o_zero, o_ovf, o_udf}), 32'({e.ezf, e.eovf, e.eudf}));
        end
    endtask

    initial begin
        logic [WIDTH-1:0] h_sg;
        logic [EXPW-1:0]  h_exp;
        logic [2:0]       h_fl;
        bit               leak;

        //              sn    sg           exp   zero  esn   esg         eexp  zf  ovf udf lat
        vecs[0]  = mk(1'b0, 25'h0800000, 8'd127, 1'b0, 1'b0, 24'h800000, 8'd127, 0, 0, 0, 2);
        vecs[1]  = mk(1'b0, 25'h1000001, 8'd127, 1'b0, 1'b0, 24'h800000, 8'd128, 0, 0, 0, 3);
        vecs[2]  = mk(1'b0, 25'h0000001, 8'd30,  1'b0, 1'b0, 24'h800000, 8'd7,   0, 0, 0, 25);
        vecs[3]  = mk(1'b0, 25'h0000001, 8'd10,  1'b0, 1'b0, 24'h000200, 8'd0,   0, 0, 1, 11);
        vecs[4]  = mk(1'b1, 25'h0000123, 8'd50,  1'b1, 1'b1, 24'h000000, 8'd0,   1, 0, 0, 2);
        vecs[5]  = mk(1'b0, 25'h1800000, 8'd254, 1'b0, 1'b0, 24'h000000, 8'd255, 0, 1, 0, 2);
        vecs[6]  = mk(1'b1, 25'h0000000, 8'd5,   1'b0, 1'b1, 24'h000000, 8'd0,   1, 0, 0, 2);
        vecs[7]  = mk(1'b0, 25'h0C00000, 8'd255, 1'b0, 1'b0, 24'h000000, 8'd255, 0, 1, 0, 2);
        vecs[8]  = mk(1'b0, 25'h0400000, 8'd0,   1'b0, 1'b0, 24'h400000, 8'd0,   0, 0, 1, 2);
        vecs[9]  = mk(1'b1, 25'h0000001, 8'd100, 1'b0, 1'b1, 24'h800000, 8'd77,  0, 0, 0, 25);
        vecs[10] = mk(1'b0, 25'h1FFFFFF, 8'd200, 1'b0, 1'b0, 24'hFFFFFF, 8'd201, 0, 0, 0, 3);
        vecs[11] = mk(1'b0, 25'h0012345, 8'd2,   1'b0, 1'b0, 24'h02468A, 8'd0,   0, 0, 1, 3);
        vecs[12] = mk(1'b1, 25'h0600000, 8'd1,   1'b0, 1'b1, 24'h600000, 8'd0,   0, 0, 1, 2);
        vecs[13] = mk(1'b0, 25'h1000000, 8'd253, 1'b0, 1'b0, 24'h800000, 8'd254, 0, 0, 0, 3);

        nrst = 1'b0; i_valid = 1'b0; i_sn = 1'b0; i_sg = '0; i_exp = '0; i_zero = 1'b0; i_rdy = 1'b1;
        #12;
        chk("rst.valid", 32'(o_valid), 32'd0);
        chk("rst.data", 32'({o_sn, o_sg}), 32'd0);
        chk("rst.exp_flags", 32'({o_exp, o_zero, o_ovf, o_udf}), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        chk("rst.rdy_after", 32'(o_rdy), 32'd1);

        for (int k = 0; k < 14; k++) run_vec(vecs[k], $sformatf("v%0d", k));

        // Back-pressure: result must hold while i_rdy is low
        @(negedge clk);
        i_rdy = 1'b0;
        run_vec(vecs[1], "hold");
        h_sg = o_sg; h_exp = o_exp; h_fl = {o_zero, o_ovf, o_udf};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("hold.valid", 32'(o_valid), 32'd1);
            chk("hold.rdy", 32'(o_rdy), 32'd0);
            chk("hold.data", 32'({o_sg, o_exp}), 32'({h_sg, h_exp}));
            chk("hold.flags", 32'({o_zero, o_ovf, o_udf}), 32'(h_fl));
        end
        i_rdy = 1'b1;
        @(negedge clk);
        chk("release.valid", 32'(o_valid), 32'd0);
        chk("release.rdy", 32'(o_rdy), 32'd1);

        // Reset in the middle of a long left-shift run discards the operand
        @(negedge clk);
        i_valid = 1'b1; i_sn = 1'b1; i_sg = 25'h0000001; i_exp = 8'd100; i_zero = 1'b0;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid.busy", 32'({o_valid, o_rdy}), 32'd0);
        #2 nrst = 1'b0;
        #1;
        chk("mid.rst_valid", 32'(o_valid), 32'd0);
        chk("mid.rst_data", 32'({o_sn, o_sg, o_exp}), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        leak = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (o_valid || !o_rdy) leak = 1'b1;
        end
        chk("mid.no_result", 32'(leak), 32'd0);

        run_vec(vecs[0], "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
